// File: rtl/instruction_loader.sv
// Packs a host byte stream big-endian into 32-bit words and writes them to
// the instruction memory from a programmable base, stalling the CPU meanwhile.
module instruction_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_Address,
    input  logic [7:0]            Byte_Data,
    input  logic                  Byte_Valid,
    input  logic                  Byte_Last,
    output logic                  Byte_Ready,
    output logic                  Write_Enable,
    output logic [ADDR_WIDTH-1:0] Write_Address,
    output logic [31:0]           Write_Data,
    output logic                  Busy,
    output logic                  CPU_Hold,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH:0]   Words_Written
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           word_q;
    logic [1:0]            idx_q;
    logic                  last_q;
    logic                  ready_q;
    logic                  we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [ADDR_WIDTH:0]   words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            words_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        state_q <= StRecv;
                        addr_q  <= Base_Address;
                        word_q  <= '0;
                        idx_q   <= '0;
                        last_q  <= 1'b0;
                        words_q <= '0;
                        error_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StRecv: begin
                    if (Byte_Valid) begin
                        unique case (idx_q)
                            2'd0: word_q[31:24] <= Byte_Data;
                            2'd1: word_q[23:16] <= Byte_Data;
                            2'd2: word_q[15:8]  <= Byte_Data;
                            default: word_q[7:0] <= Byte_Data;
                        endcase
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3 || Byte_Last) begin
                            state_q <= StWrite;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                            last_q  <= Byte_Last;
                            // Short final word: unfilled bytes stay zero from the clear
                            if (Byte_Last && idx_q != 2'd3) begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                end
                StWrite: begin
                    we_q    <= 1'b0;
                    addr_q  <= addr_q + 1'b1;
                    words_q <= words_q + 1'b1;
                    idx_q   <= '0;
                    word_q  <= '0;
                    // Top of memory ends the session rather than wrapping to 0
                    if (last_q || addr_q == '1) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        if (!last_q) begin
                            error_q <= 1'b1;
                        end
                    end else begin
                        state_q <= StRecv;
                        ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Byte_Ready    = ready_q;
    assign Write_Enable  = we_q;
    assign Write_Address = addr_q;
    assign Write_Data    = word_q;
    assign Busy          = busy_q;
    assign CPU_Hold      = busy_q;
    assign Done          = done_q;
    assign Error         = error_q;
    assign Words_Written = words_q;

endmodule
